// File: rtl/chess_game_fsm.sv
// Chess game sequencer: START -> CHESS -> WHITE/BLACK turns -> END, with a
// per-player countdown clock (Fischer increment), timeout and resignation.
module chess_game_fsm #(
    parameter int TICK_DIV          = 50000000,
    parameter int START_SECONDS     = 300,
    parameter int INCREMENT_SECONDS = 2,
    parameter int TIME_W            = 12
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Switch,
    input  logic              DrawDone,
    input  logic              MoveDone,
    input  logic              Resign,
    output logic [2:0]        State,
    output logic [TIME_W-1:0] WhiteTime,
    output logic [TIME_W-1:0] BlackTime,
    output logic [1:0]        Winner,
    output logic              Timeout,
    output logic              Tick
);

    localparam int PSC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] T_INIT   = TIME_W'(START_SECONDS);
    localparam logic [TIME_W-1:0] T_MAX    = '1;
    localparam logic [TIME_W-1:0] T_ONE    = TIME_W'(1);
    localparam logic [1:0]        WIN_NONE  = 2'b00;
    localparam logic [1:0]        WIN_WHITE = 2'b01;
    localparam logic [1:0]        WIN_BLACK = 2'b10;

    typedef enum logic [2:0] {
        ST_START = 3'b000,
        ST_CHESS = 3'b001,
        ST_WHITE = 3'b010,
        ST_BLACK = 3'b011,
        ST_END   = 3'b100
    } state_e;

    state_e            state_q, state_d;
    logic [TIME_W-1:0] white_q, white_d;
    logic [TIME_W-1:0] black_q, black_d;
    logic [1:0]        winner_q, winner_d;
    logic              timeout_q, timeout_d;
    logic              tick_q, tick_d;
    logic [PSC_W-1:0]  psc_q, psc_d;

    logic              wrap;
    logic              is_white;
    logic [TIME_W-1:0] act_time;
    logic [TIME_W-1:0] act_next;

    function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] t);
        logic [TIME_W:0] s;
        s = {1'b0, t} + (TIME_W+1)'(INCREMENT_SECONDS);
        return (s > {1'b0, T_MAX}) ? T_MAX : s[TIME_W-1:0];
    endfunction

    assign wrap     = (psc_q == PSC_LAST);
    assign is_white = (state_q == ST_WHITE);
    assign act_time = is_white ? white_q : black_q;

    always_comb begin
        state_d   = state_q;
        white_d   = white_q;
        black_d   = black_q;
        winner_d  = winner_q;
        timeout_d = timeout_q;
        tick_d    = 1'b0;
        psc_d     = psc_q;
        act_next  = act_time;

        case (state_q)
            ST_START: begin
                white_d   = T_INIT;
                black_d   = T_INIT;
                winner_d  = WIN_NONE;
                timeout_d = 1'b0;
                psc_d     = '0;
                if (Switch) state_d = ST_CHESS;
            end
            ST_CHESS: begin
                psc_d = '0;
                if (DrawDone) state_d = ST_WHITE;
            end
            ST_WHITE, ST_BLACK: begin
                // Prescaler free-runs across turn changes so both players share
                // the same second boundary.
                psc_d = wrap ? '0 : psc_q + PSC_W'(1);
                if (Resign) begin
                    state_d  = ST_END;
                    winner_d = is_white ? WIN_BLACK : WIN_WHITE;
                end else if (MoveDone) begin
                    act_next = sat_add(act_time);
                    state_d  = is_white ? ST_BLACK : ST_WHITE;
                    tick_d   = wrap;
                end else if (wrap) begin
                    tick_d   = 1'b1;
                    act_next = act_time - T_ONE;
                    if (act_time == T_ONE) begin
                        state_d   = ST_END;
                        winner_d  = is_white ? WIN_BLACK : WIN_WHITE;
                        timeout_d = 1'b1;
                    end
                end
                if (is_white) white_d = act_next;
                else          black_d = act_next;
            end
            ST_END: ;
            default: state_d = ST_START;
        endcase

        // Dropping the enable (or an illegal encoding) reinitialises everything.
        if ((state_q != ST_START && !Switch) ||
            !(state_q inside {ST_START, ST_CHESS, ST_WHITE, ST_BLACK, ST_END})) begin
            state_d   = ST_START;
            white_d   = T_INIT;
            black_d   = T_INIT;
            winner_d  = WIN_NONE;
            timeout_d = 1'b0;
            tick_d    = 1'b0;
            psc_d     = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= ST_START;
            white_q   <= T_INIT;
            black_q   <= T_INIT;
            winner_q  <= WIN_NONE;
            timeout_q <= 1'b0;
            tick_q    <= 1'b0;
            psc_q     <= '0;
        end else begin
            state_q   <= state_d;
            white_q   <= white_d;
            black_q   <= black_d;
            winner_q  <= winner_d;
            timeout_q <= timeout_d;
            tick_q    <= tick_d;
            psc_q     <= psc_d;
        end
    end

    assign State     = state_q;
    assign WhiteTime = white_q;
    assign BlackTime = black_q;
    assign Winner    = winner_q;
    assign Timeout   = timeout_q;
    assign Tick      = tick_q;

endmodule

// File: tb/tb_chess_game_fsm.sv
// Bench for chess_game_fsm: three parameterisations share one stimulus stream
// and are checked every cycle against a rule-level game model.
module tb_chess_game_fsm;

    logic Clock = 1'b0;
    logic Reset, Switch, DrawDone, MoveDone, Resign;

    always #5 Clock = ~Clock;

    logic [2:0]  st  [3];
    logic [11:0] wt  [3];
    logic [11:0] bt  [3];
    logic [1:0]  win [3];
    logic        to  [3];
    logic        tk  [3];
    logic [3:0]  wt_b, bt_b;

    assign wt[1] = {8'd0, wt_b};
    assign bt[1] = {8'd0, bt_b};

    chess_game_fsm #(.TICK_DIV(4), .START_SECONDS(3), .INCREMENT_SECONDS(2), .TIME_W(12)) u_a (
        .Clock(Clock), .Reset(Reset), .Switch(Switch), .DrawDone(DrawDone),
        .MoveDone(MoveDone), .Resign(Resign), .State(st[0]), .WhiteTime(wt[0]),
        .BlackTime(bt[0]), .Winner(win[0]), .Timeout(to[0]), .Tick(tk[0]));

    chess_game_fsm #(.TICK_DIV(4), .START_SECONDS(14), .INCREMENT_SECONDS(3), .TIME_W(4)) u_b (
        .Clock(Clock), .Reset(Reset), .Switch(Switch), .DrawDone(DrawDone),
        .MoveDone(MoveDone), .Resign(Resign), .State(st[1]), .WhiteTime(wt_b),
        .BlackTime(bt_b), .Winner(win[1]), .Timeout(to[1]), .Tick(tk[1]));

    chess_game_fsm #(.TICK_DIV(4), .START_SECONDS(300), .INCREMENT_SECONDS(2), .TIME_W(12)) u_c (
        .Clock(Clock), .Reset(Reset), .Switch(Switch), .DrawDone(DrawDone),
        .MoveDone(MoveDone), .Resign(Resign), .State(st[2]), .WhiteTime(wt[2]),
        .BlackTime(bt[2]), .Winner(win[2]), .Timeout(to[2]), .Tick(tk[2]));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Game model: mode 0 START, 1 CHESS, 2 WHITE, 3 BLACK, 4 END.
    int P_TD  [3] = '{4, 4, 4};
    int P_SS  [3] = '{3, 14, 300};
    int P_INC [3] = '{2, 3, 2};
    int P_MAX [3] = '{4095, 15, 4095};

    int m_mode [3], m_wt [3], m_bt [3], m_win [3], m_to [3], m_tk [3], m_sec [3];
    bit armed = 0;

    task automatic fresh(input int k);
        m_mode[k] = 0; m_wt[k] = P_SS[k]; m_bt[k] = P_SS[k];
        m_win[k] = 0; m_to[k] = 0; m_tk[k] = 0; m_sec[k] = 0;
    endtask

    task automatic model_step(input int k);
        bit boundary;
        int t;
        int mover_wins_to;
        m_tk[k] = 0;
        if (!Reset) begin
            fresh(k);
            return;
        end
        if (m_mode[k] != 0 && !Switch) begin
            fresh(k);
            return;
        end
        if (m_mode[k] == 0) begin
            fresh(k);
            if (Switch) m_mode[k] = 1;
        end else if (m_mode[k] == 1) begin
            m_sec[k] = 0;
            if (DrawDone) m_mode[k] = 2;
        end else if (m_mode[k] == 2 || m_mode[k] == 3) begin
            boundary = (m_sec[k] == P_TD[k] - 1);
            m_sec[k] = (m_sec[k] + 1) % P_TD[k];
            t = (m_mode[k] == 2) ? m_wt[k] : m_bt[k];
            mover_wins_to = (m_mode[k] == 2) ? 2 : 1;
            if (Resign) begin
                m_win[k]  = mover_wins_to;
                m_mode[k] = 4;
            end else if (MoveDone) begin
                t = (t + P_INC[k] > P_MAX[k]) ? P_MAX[k] : t + P_INC[k];
                m_tk[k] = boundary;
                if (m_mode[k] == 2) begin m_wt[k] = t; m_mode[k] = 3; end
                else                begin m_bt[k] = t; m_mode[k] = 2; end
            end else if (boundary) begin
                m_tk[k] = 1;
                t = t - 1;
                if (m_mode[k] == 2) m_wt[k] = t; else m_bt[k] = t;
                if (t == 0) begin
                    m_win[k] = mover_wins_to;
                    m_to[k]  = 1;
                    m_mode[k] = 4;
                end
            end
        end
    endtask

    initial for (int k = 0; k < 3; k++) fresh(k);

    always @(posedge Clock) begin
        for (int k = 0; k < 3; k++) model_step(k);
        if (!Reset) armed = 1;
    end

    always @(negedge Clock) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("state[%0d]", k),   32'(st[k]),  32'(m_mode[k]));
                chk($sformatf("wtime[%0d]", k),   32'(wt[k]),  32'(m_wt[k]));
                chk($sformatf("btime[%0d]", k),   32'(bt[k]),  32'(m_bt[k]));
                chk($sformatf("winner[%0d]", k),  32'(win[k]), 32'(m_win[k]));
                chk($sformatf("timeout[%0d]", k), 32'(to[k]),  32'(m_to[k]));
                chk($sformatf("tick[%0d]", k),    32'(tk[k]),  32'(m_tk[k]));
            end
        end
    end

    // Inputs apply to the next edge; returns 1 time unit after that edge.
    task automatic drive(input bit sw, input bit dd = 0, input bit md = 0,
                         input bit rs = 0, input bit rst_n = 1);
        Reset = rst_n; Switch = sw; DrawDone = dd; MoveDone = md; Resign = rs;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1);
    endtask

    initial begin
        Reset = 0; Switch = 0; DrawDone = 0; MoveDone = 0; Resign = 0;
        drive(0, 0, 0, 0, 0);
        chk("rst_state", 32'(st[0]), 0);
        chk("rst_wtime", 32'(wt[0]), 3);
        chk("rst_wtime_c", 32'(wt[2]), 300);

        // Timeout: white never moves.
        drive(1);
        chk("to_chess", 32'(st[0]), 1);
        drive(1, 1);
        chk("to_white", 32'(st[0]), 2);
        idle(4);
        chk("to_w2", 32'(wt[0]), 2);
        chk("to_tick", 32'(tk[0]), 1);
        idle(4);
        chk("to_w1", 32'(wt[0]), 1);
        idle(4);
        chk("to_w0", 32'(wt[0]), 0);
        chk("to_end", 32'(st[0]), 4);
        chk("to_winner", 32'(win[0]), 2);
        chk("to_flag", 32'(to[0]), 1);
        chk("to_btime", 32'(bt[0]), 3);
        chk("to_c_run", 32'(wt[2]), 297);

        // Increment, saturation and post-move tick attribution.
        drive(0);
        drive(1);
        drive(1, 1);
        drive(1, 0, 1);
        chk("inc_state", 32'(st[2]), 3);
        chk("inc_w302", 32'(wt[2]), 302);
        chk("sat_w15", 32'(wt[1]), 15);
        chk("inc_a_w5", 32'(wt[0]), 5);
        idle(3);
        chk("inc_tick", 32'(tk[2]), 1);
        chk("inc_b299", 32'(bt[2]), 299);
        chk("inc_w_hold", 32'(wt[2]), 302);

        // Move coincident with tick: increment only, no decrement.
        drive(1, 0, 1);
        chk("co_white", 32'(st[0]), 2);
        idle(2);
        drive(1, 0, 1);
        chk("co_w7", 32'(wt[0]), 7);
        chk("co_black", 32'(st[0]), 3);

        // Resign beats MoveDone; END ignores further moves.
        drive(1, 0, 1, 1);
        chk("rs_end", 32'(st[0]), 4);
        chk("rs_winner", 32'(win[0]), 1);
        chk("rs_timeout", 32'(to[0]), 0);
        drive(1, 0, 1);
        chk("rs_frozen", 32'(wt[0]), 7);

        // Switch drop mid-BLACK, then reset pulse mid-WHITE.
        drive(0);
        drive(1);
        drive(1, 1);
        drive(1, 0, 1);
        drive(0);
        chk("sw_start", 32'(st[0]), 0);
        chk("sw_wtime", 32'(wt[0]), 3);
        drive(1);
        drive(1, 1);
        idle(5);
        drive(1, 0, 0, 0, 0);
        chk("rr_state", 32'(st[2]), 0);
        chk("rr_wtime", 32'(wt[2]), 300);

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(63) != 0), ($urandom_range(3) == 0),
                  ($urandom_range(7) == 0), ($urandom_range(63) == 0),
                  ($urandom_range(255) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
